// File: rtl/lcm_unit_pkg.sv
// Shared definitions for the LCM unit: FSM encoding and default operand width.
package lcm_unit_pkg;

   localparam int WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/lcm_unit_if.sv
// Operand/result handshake bundle between the gcd core, the LCM unit and the sink.
interface lcm_unit_if
   import lcm_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic [WIDTH-1:0]   m_in;
   logic [WIDTH-1:0]   n_in;
   logic [WIDTH-1:0]   gcd_in;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] lcm_out;
   logic               lcm_err;
   logic               out_valid;
   logic               out_ready;

   // Environment side: drives operands and sink ready.
   modport master (
      output m_in, n_in, gcd_in, in_valid, out_ready,
      input  in_ready, lcm_out, lcm_err, out_valid
   );

   // LCM unit side.
   modport slave (
      input  m_in, n_in, gcd_in, in_valid, out_ready,
      output in_ready, lcm_out, lcm_err, out_valid
   );
endinterface

// File: rtl/lcm_unit_serdiv.sv
// Serial restoring divider: WIDTH steps after start, one quotient bit per clock, MSB first.
module lcm_serdiv
   import lcm_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             last_o,
   output logic [WIDTH-1:0] quo_o
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] dvd_q, dvs_q, quo_q;
   logic [WIDTH:0]   rem_q, rem_sh, rem_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, ge;

   // One restoring step: shift in next dividend bit, subtract divisor if it fits.
   // Remainder carries one extra bit so the compare never overflows.
   always_comb begin
      rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, dvs_q});
      rem_d  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
   end

   // Operand capture on start, then WIDTH iterations while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         dvd_q  <= dividend_i;
         dvs_q  <= divisor_i;
         quo_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= CW'(WIDTH-1);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         dvd_q <= dvd_q << 1;
         rem_q <= rem_d;
         quo_q <= {quo_q[WIDTH-2:0], ge};
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) busy_q <= 1'b0;
      end
   end

   assign busy_o = busy_q;
   assign last_o = (cnt_q == '0);
   assign quo_o  = quo_q;
endmodule

// File: rtl/lcm_unit.sv
// LCM stage: lcm = (m / gcd) * n via serial divide then serial shift-add multiply.
module lcm_unit
   import lcm_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   lcm_unit_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, mcand_q;
   logic [CW-1:0]      k_q;
   logic               err_q, vld_q;
   logic               accept, gcd_zero, div_start, div_busy, div_last;
   logic [WIDTH-1:0]   quo;

   assign accept    = (state_q == S_IDLE) && bus.in_valid;
   assign gcd_zero  = (bus.gcd_in == '0);
   assign div_start = accept && !gcd_zero;

   lcm_serdiv #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (bus.m_in),
      .divisor_i  (bus.gcd_in),
      .busy_o     (div_busy),
      .last_o     (div_last),
      .quo_o      (quo)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: a zero gcd skips both arithmetic phases and reports an error.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.in_valid) state_d = gcd_zero ? S_DONE : S_DIV;
         S_DIV:  if (div_busy && div_last) state_d = S_MUL;
         S_MUL:  if (k_q == CW'(WIDTH-1)) state_d = S_DONE;
         S_DONE: if (vld_q && bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shift-add multiplier and result/valid registers. Valid rises with the entry
   // into DONE on the normal path; on the error path it rises one cycle after entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         mcand_q <= '0;
         k_q     <= '0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               acc_q   <= '0;
               mcand_q <= {{WIDTH{1'b0}}, bus.n_in};
               k_q     <= '0;
               err_q   <= gcd_zero;
               vld_q   <= 1'b0;
            end
            S_MUL: begin
               if (quo[k_q]) acc_q <= acc_q + mcand_q;
               mcand_q <= mcand_q << 1;
               k_q     <= k_q + 1'b1;
               if (k_q == CW'(WIDTH-1)) vld_q <= 1'b1;
            end
            S_DONE: begin
               if (!vld_q)              vld_q <= 1'b1;
               else if (bus.out_ready)  vld_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.lcm_out   = acc_q;
   assign bus.lcm_err   = err_q;
   assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_lcm_unit.sv
// Scoreboard bench for lcm_unit: stimulus pushes expected results, a monitor pops on handshake.
module tb_lcm_unit;
   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] lcm;
      logic           err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   lcm_unit_if #(.WIDTH(W)) bus ();
   lcm_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare each accepted result against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got lcm %0d err %0d, expected nothing", bus.lcm_out, bus.lcm_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("lcm_out", 64'(bus.lcm_out), 64'(e.lcm));
            check("lcm_err", 64'(bus.lcm_err), 64'(e.err));
         end
      end
   end

   task automatic issue(input logic [W-1:0] m, input logic [W-1:0] n, input logic [W-1:0] g,
                        input bit push, input logic [2*W-1:0] elcm, input bit eerr,
                        output int tacc);
      exp_t e;
      @(negedge clk);
      bus.m_in = m; bus.n_in = n; bus.gcd_in = g; bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
      if (!bus.in_ready) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      tacc = cyc;
      bus.in_valid = 1'b0;
      bus.m_in = '1; bus.n_in = '1; bus.gcd_in = '1;
      if (push) begin
         e.lcm = elcm;
         e.err = eerr;
         sb.push_back(e);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int t1, t2, lat;
      bus.m_in = '0; bus.n_in = '0; bus.gcd_in = '0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #12;
      check("rst_in_ready", 64'(bus.in_ready), 1);
      check("rst_out_valid", 64'(bus.out_valid), 0);
      check("rst_lcm_out", 64'(bus.lcm_out), 0);
      check("rst_lcm_err", 64'(bus.lcm_err), 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: basic, latency 2*W
      issue(16'd2322, 16'd654, 16'd6, 1, 32'd253098, 0, t1);
      wait_valid(lat);
      check("t1_latency", 64'(lat), 32);
      @(posedge clk); #1;
      check("t1_valid_drop", 64'(bus.out_valid), 0);

      // 2: full-range product
      issue(16'd65535, 16'd65534, 16'd1, 1, 32'd4294770690, 0, t1);
      wait_valid(lat);
      check("t2_latency", 64'(lat), 32);
      @(posedge clk); #1;

      // 3: gcd=0 error path, held until drained
      bus.out_ready = 1'b0;
      issue(16'd0, 16'd0, 16'd0, 1, 32'd0, 1, t1);
      wait_valid(lat);
      check("t3_latency", 64'(lat), 1);
      @(posedge clk); #1;
      check("t3_in_ready_busy", 64'(bus.in_ready), 0);
      check("t3_valid_held", 64'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_in_ready_after", 64'(bus.in_ready), 1);
      check("t3_valid_after", 64'(bus.out_valid), 0);

      // 4: sink stall with ignored in_valid pulses
      bus.out_ready = 1'b0;
      issue(16'd12, 16'd18, 16'd6, 1, 32'd36, 0, t1);
      wait_valid(lat);
      check("t4_latency", 64'(lat), 32);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.m_in = 16'd99; bus.n_in = 16'd77; bus.gcd_in = 16'd1;
         @(posedge clk); #1;
         check("t4_hold_lcm", 64'(bus.lcm_out), 36);
         check("t4_hold_valid", 64'(bus.out_valid), 1);
         check("t4_hold_in_ready", 64'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_idle", 64'(bus.in_ready), 1);

      // 5: reset mid-divide discards the operation
      issue(16'd2322, 16'd654, 16'd6, 0, 32'd0, 0, t1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5_valid_rst", 64'(bus.out_valid), 0);
      check("t5_in_ready_rst", 64'(bus.in_ready), 1);
      check("t5_lcm_rst", 64'(bus.lcm_out), 0);
      @(negedge clk);
      rst = 1'b0;
      issue(16'd7, 16'd5, 16'd1, 1, 32'd35, 0, t1);
      wait_valid(lat);
      check("t5_latency", 64'(lat), 32);
      @(posedge clk); #1;

      // 6: back-to-back throughput
      issue(16'd12, 16'd18, 16'd6, 1, 32'd36, 0, t1);
      issue(16'd7, 16'd5, 16'd1, 1, 32'd35, 0, t2);
      check("t6_spacing", 64'(t2 - t1), 2*W+2);
      for (int i = 0; i < 100 && (sb.size() != 0 || bus.out_valid); i++) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
